// File: rtl/store_beat_aligner.sv
// Store-data aligner: places 1/2/4/8-byte stores into DATA_W-bit bus lanes with byte strobes.
// Optional STORE_SPLIT_EN splits a misaligned store that crosses a bus word into two beats.
module store_beat_aligner #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [63:0]           req_data,
    input  logic [1:0]            req_msize,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_data,
    output logic [DATA_W/8-1:0]   bus_strobe,
    output logic                  bus_last,
    output logic                  err_valid,
    output logic [ADDR_W-1:0]     err_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int EXT_W = (DATA_W > 64) ? DATA_W : 64;
`ifdef STORE_SPLIT_EN
    localparam int LANES = 2 * BYTES;
`else
    localparam int LANES = BYTES;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BEAT0
`ifdef STORE_SPLIT_EN
        , BEAT1
`endif
    } state_e;

    state_e state_q, state_d;

    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [BYTES-1:0]    bus_strobe_q, bus_strobe_d;
    logic                bus_last_q, bus_last_d;
    logic                err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
`ifdef STORE_SPLIT_EN
    logic [DATA_W-1:0]   hi_data_q, hi_data_d;
    logic [BYTES-1:0]    hi_strb_q, hi_strb_d;
`endif

    logic [OFF_W-1:0]    off;
    logic [31:0]         off_u;
    logic [31:0]         n_u;
    logic [ADDR_W-1:0]   base;
    logic [EXT_W-1:0]    rd_ext;
    logic [8*LANES-1:0]  wide_data;
    logic [LANES-1:0]    wide_strb;
    logic                too_big;
    logic                misaligned;
    logic                req_err;
    logic                accept;

    assign off        = req_addr[OFF_W-1:0];
    assign off_u      = 32'(off);
    assign n_u        = 32'd1 << req_msize;
    assign base       = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign rd_ext     = EXT_W'(req_data);
    assign too_big    = n_u > 32'(BYTES);
    assign misaligned = (off_u & (n_u - 32'd1)) != '0;
`ifdef STORE_SPLIT_EN
    assign req_err    = too_big;
`else
    assign req_err    = too_big | misaligned;
`endif

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Lane j carries store byte (j - off); lanes past BYTES form the second beat.
    always_comb begin
        wide_data = '0;
        wide_strb = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (j >= off_u && j < off_u + n_u) begin
                if (j - off_u < 32'(BYTES)) begin
                    wide_strb[j]        = 1'b1;
                    wide_data[8*j +: 8] = rd_ext[8*(j-off_u) +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        bus_strobe_d = bus_strobe_q;
        bus_last_d   = bus_last_q;
        err_valid_d  = 1'b0;
        err_addr_d   = err_addr_q;
`ifdef STORE_SPLIT_EN
        hi_data_d    = hi_data_q;
        hi_strb_d    = hi_strb_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = req_addr;
                    end else begin
                        state_d      = BEAT0;
                        bus_valid_d  = 1'b1;
                        bus_addr_d   = base;
                        bus_data_d   = wide_data[DATA_W-1:0];
                        bus_strobe_d = wide_strb[BYTES-1:0];
                        bus_last_d   = 1'b1;
`ifdef STORE_SPLIT_EN
                        hi_data_d    = wide_data[2*DATA_W-1:DATA_W];
                        hi_strb_d    = wide_strb[2*BYTES-1:BYTES];
                        bus_last_d   = (wide_strb[2*BYTES-1:BYTES] == '0);
`endif
                    end
                end
            end
            BEAT0: begin
                if (bus_ready) begin
`ifdef STORE_SPLIT_EN
                    if (!bus_last_q) begin
                        state_d      = BEAT1;
                        bus_addr_d   = bus_addr_q + ADDR_W'(BYTES);
                        bus_data_d   = hi_data_q;
                        bus_strobe_d = hi_strb_q;
                        bus_last_d   = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        bus_valid_d = 1'b0;
                        bus_last_d  = 1'b0;
                    end
`else
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                    bus_last_d  = 1'b0;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            BEAT1: begin
                if (bus_ready) begin
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                    bus_last_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
                bus_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_strobe_q <= '0;
            bus_last_q   <= 1'b0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
`ifdef STORE_SPLIT_EN
            hi_data_q    <= '0;
            hi_strb_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_strobe_q <= bus_strobe_d;
            bus_last_q   <= bus_last_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
`ifdef STORE_SPLIT_EN
            hi_data_q    <= hi_data_d;
            hi_strb_q    <= hi_strb_d;
`endif
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_data   = bus_data_q;
    assign bus_strobe = bus_strobe_q;
    assign bus_last   = bus_last_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;

endmodule
